// File: rtl/sum_accumulator.sv
// sum_accumulator: streaming frame accumulator.
//   Accepts BIT_WIDTH-bit unsigned samples over a valid/ready handshake and
//   sums SAMPLE_COUNT of them through one adder_nbit. It then presents the frame
//   total (modulo 2^BIT_WIDTH) and a sticky carry-out flag, and holds them until
//   they are consumed.
//
// Ports (sum_accumulator):
//   clk          in   1          system clock, rising edge
//   rst          in   1          synchronous reset, active-high
//   clear        in   1          synchronous frame abort, active-high
//   in_valid     in   1          in_data is valid this cycle
//   in_ready     out  1          block can accept a sample this cycle
//   in_data      in   BIT_WIDTH  sample, unsigned
//   out_valid    out  1          frame result valid
//   out_ready    in   1          consumer takes result this cycle
//   out_sum      out  BIT_WIDTH  frame total, modulo 2^BIT_WIDTH
//   out_overflow out  1          any adder carry-out during the frame
//
// Ports (adder_nbit):
//   a, b         in   BIT_WIDTH  unsigned operands
//   carry_in     in   1          carry into bit 0
//   sum          out  BIT_WIDTH  a + b + carry_in, modulo 2^BIT_WIDTH
//   overflow     out  1          carry out of the top bit

module adder_nbit #(
    parameter int unsigned BIT_WIDTH = 4
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);
    logic [BIT_WIDTH:0] w_full;

    assign w_full   = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};
    assign sum      = w_full[BIT_WIDTH-1:0];
    assign overflow = w_full[BIT_WIDTH];
endmodule

module sum_accumulator #(
    parameter int unsigned BIT_WIDTH    = 4,
    parameter int unsigned SAMPLE_COUNT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_sum,
    output logic                 out_overflow
);
    localparam int unsigned     CW       = $clog2(SAMPLE_COUNT) + 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(SAMPLE_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_t;

    state_t               r_state;
    logic [BIT_WIDTH-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_ovf;
    logic                 r_in_ready;
    logic                 r_out_valid;

    logic                 w_accept;
    logic [BIT_WIDTH-1:0] w_sum;
    logic                 w_carry;

    adder_nbit #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_adder (
        .a       (in_data),
        .b       (r_acc),
        .carry_in(1'b0),
        .sum     (w_sum),
        .overflow(w_carry)
    );

    // Handshake uses the registered ready only, so a sample can never be
    // taken in the same cycle a held result is consumed.
    assign w_accept = in_valid & r_in_ready;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_carry;
                        r_cnt <= r_cnt + CW'(1);
                        // cnt is 0 in IDLE, so a one-sample frame goes straight to HOLD.
                        if (r_cnt == LAST_CNT) begin
                            r_state     <= ST_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_ovf       <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    // Partial totals stay hidden until the frame is complete.
    assign out_sum      = r_out_valid ? r_acc : '0;
    assign out_overflow = r_out_valid & r_ovf;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!$isunknown(clear))
                else $error("sum_accumulator: clear is X/Z");
            assert (!(clear === 1'b0 && in_valid === 1'b1 && r_in_ready === 1'b1
                      && $isunknown(in_data)))
                else $error("sum_accumulator: accepted in_data is X/Z");
        end
    end
`endif
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed plus randomized stimulus for sum_accumulator
// (BIT_WIDTH=4, SAMPLE_COUNT=4), checked every cycle against a frame-level
// reference model built from a sample queue and plain integer arithmetic.

module tb_sum_accumulator;
    localparam int unsigned BW = 4;
    localparam int unsigned SC = 4;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_sum;
    logic          out_overflow;

    sum_accumulator #(
        .BIT_WIDTH   (BW),
        .SAMPLE_COUNT(SC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_overflow(out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: samples of the current frame, plus the held result.
    int unsigned m_q[$];
    bit          m_known = 0;
    bit          m_hold  = 0;
    int unsigned m_sum   = 0;
    bit          m_ovf   = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare the present outputs with the model, then apply one cycle of inputs.
    // Called with the clock low; returns at the next falling edge.
    task automatic step(input logic r, input logic c, input logic v,
                        input logic [BW-1:0] d, input logic o);
        int unsigned tot;
        if (m_known) begin
            check_val("in_ready", 32'(in_ready), 32'(!m_hold));
            check_val("out_valid", 32'(out_valid), 32'(m_hold));
            if (m_hold) begin
                check_val("out_sum", 32'(out_sum), m_sum);
                check_val("out_overflow", 32'(out_overflow), 32'(m_ovf));
            end
        end
        rst       = r;
        clear     = c;
        in_valid  = v;
        in_data   = d;
        out_ready = o;
        if (r || c) begin
            m_q.delete();
            m_hold  = 0;
            m_known = 1;
        end else if (m_hold) begin
            if (o) m_hold = 0;
        end else if (v) begin
            m_q.push_back(int'(d));
            if (m_q.size() == SC) begin
                tot = 0;
                foreach (m_q[i]) tot += m_q[i];
                // The true total exceeds the range exactly when some add carried out.
                m_sum  = tot % (1 << BW);
                m_ovf  = (tot >= (1 << BW));
                m_hold = 1;
                m_q.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame4(input logic [BW-1:0] a, input logic [BW-1:0] b,
                          input logic [BW-1:0] c, input logic [BW-1:0] d,
                          input logic o);
        step(0, 0, 1, a, o);
        step(0, 0, 1, b, o);
        step(0, 0, 1, c, o);
        step(0, 0, 1, d, o);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_sum", 32'(out_sum), 32'd0);
        check_val("rst_out_ovf", 32'(out_overflow), 32'd0);

        // Back-to-back 1,2,3,4 with out_ready=1: one-cycle result
        frame4(4'd1, 4'd2, 4'd3, 4'd4, 1);
        check_val("b2b_valid", 32'(out_valid), 32'd1);
        check_val("b2b_sum", 32'(out_sum), 32'hA);
        check_val("b2b_ovf", 32'(out_overflow), 32'd0);
        check_val("b2b_ready", 32'(in_ready), 32'd0);
        step(0, 0, 0, 0, 1);
        check_val("b2b_valid_drop", 32'(out_valid), 32'd0);

        // Wrap sets sticky; next frame clears it
        frame4(4'd8, 4'd8, 4'd1, 4'd0, 1);
        check_val("wrap_sum", 32'(out_sum), 32'h1);
        check_val("wrap_ovf", 32'(out_overflow), 32'd1);
        step(0, 0, 0, 0, 1);
        frame4(4'd1, 4'd1, 4'd1, 4'd1, 1);
        check_val("post_wrap_sum", 32'(out_sum), 32'h4);
        check_val("post_wrap_ovf", 32'(out_overflow), 32'd0);
        step(0, 0, 0, 0, 1);

        // Backpressure with in_valid held
        frame4(4'd3, 4'd3, 4'd3, 4'd3, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 4'd9, 0);
        check_val("bp_sum", 32'(out_sum), 32'hC);
        check_val("bp_ready", 32'(in_ready), 32'd0);
        step(0, 0, 1, 4'd9, 1);
        check_val("bp_idle_ready", 32'(in_ready), 32'd1);
        check_val("bp_idle_valid", 32'(out_valid), 32'd0);

        // Gaps in in_valid
        step(0, 0, 1, 4'd3, 0);
        step(0, 0, 0, 4'd5, 0);
        step(0, 0, 0, 4'd5, 0);
        step(0, 0, 1, 4'd3, 0);
        step(0, 0, 0, 4'd5, 0);
        step(0, 0, 1, 4'd3, 0);
        check_val("gap_not_yet", 32'(out_valid), 32'd0);
        step(0, 0, 1, 4'd3, 0);
        check_val("gap_sum", 32'(out_sum), 32'hC);
        step(0, 0, 0, 0, 1);

        // Abort with clear, then with rst
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 1, 4'd5, 0);
            step(0, 0, 1, 4'd5, 0);
            if (k == 0) step(0, 1, 1, 4'd7, 0);
            else        step(1, 0, 1, 4'd7, 0);
            check_val("abort_valid", 32'(out_valid), 32'd0);
            frame4(4'd1, 4'd1, 4'd1, 4'd1, 0);
            check_val("abort_sum", 32'(out_sum), 32'h4);
            step(0, 0, 0, 0, 1);
        end

        // Clear discards a held result even with out_ready=1
        frame4(4'd2, 4'd2, 4'd2, 4'd2, 0);
        step(0, 1, 1, 4'd6, 1);
        check_val("clr_hold_valid", 32'(out_valid), 32'd0);
        check_val("clr_hold_ready", 32'(in_ready), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 9) < 7, BW'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1);
        end
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
